feature_fetch_pp: RTL and testbench

Parametrised input-feature fetch engine that streams IN_W-bit words from the external-memory read path, unpacks them into DATA_W-bit feature elements and writes them, one element per cycle, into the on-chip feature-in memory. It generalises the single-channel fetch: the feature tile is size × size × channels, the input word and element widths are parameters, and writes go to a ping-pong pair of feature-in banks. By default the bank flips after every completed tile, so the compute array can read one bank while the next tile fills the other.

---
 rtl/feature_fetch_pp.sv | 117 +++++++++++
 tb/tb_feature_fetch_pp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/feature_fetch_pp.sv
// Feature fetch engine: unpacks IN_W-bit read words into DATA_W-bit elements and
// writes one element per cycle into a ping-pong pair of feature-in banks.
module feature_fetch_pp #(
  parameter int IN_W   = 128,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int SIZE_W = 8,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] feature_size,
  input  logic [CH_W-1:0]   channels,
  input  logic              bank_hold,
  input  logic              feature_in_select,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              i_mem_select,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANES = IN_W / DATA_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW    = 2 * SIZE_W + CH_W;
  localparam logic [TW:0] DEPTH = (TW+1)'(1) << ADDR_W;

  // Handshake: a word moves on a cycle where i_valid && i_ready; i_ready never
  // depends on i_valid, so the source may hold or drop valid at will.
  typedef enum logic [1:0] {IDLE, FETCH, FINISH} state_t;
  state_t state, state_n;

  logic [TW-1:0]   total_in, total_q, cnt;
  logic [TW:0]     words_in, words_q, acc_cnt;
  logic [IN_W-1:0] buf_q;
  logic [LW-1:0]   lane_q;
  logic            too_big, empty, accept, last_lane, last_elem;

  assign total_in  = TW'(feature_size) * TW'(feature_size) * TW'(channels);
  assign words_in  = ({1'b0, total_in} + (TW+1)'(LANES - 1)) / (TW+1)'(LANES);
  assign too_big   = {1'b0, total_in} > DEPTH;
  assign empty     = (total_in == '0);
  assign last_lane = (lane_q == LW'(LANES - 1));
  assign last_elem = (cnt == total_q - TW'(1));

  // wr_en doubles as "buffer holds an unwritten lane"; refill only as it drains.
  assign i_ready = (state == FETCH) && (acc_cnt < words_q) && (!wr_en || last_lane);
  assign accept  = i_valid && i_ready;
  assign busy    = (state == FETCH);
  assign done    = (state == FINISH);
  assign wr_addr = cnt[ADDR_W-1:0];
  assign wr_data = buf_q[int'(lane_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (too_big || empty) ? FINISH : FETCH;
      FETCH:   if (wr_en && last_elem) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q      <= '0;
      words_q      <= '0;
      acc_cnt      <= '0;
      cnt          <= '0;
      buf_q        <= '0;
      lane_q       <= '0;
      wr_en        <= 1'b0;
      i_mem_select <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_en <= 1'b0;
          if (start) begin
            total_q <= total_in;
            words_q <= words_in;
            acc_cnt <= '0;
            cnt     <= '0;
            err     <= too_big;
            if (!too_big) i_mem_select <= bank_hold ? feature_in_select : ~i_mem_select;
          end
        end
        FETCH: begin
          if (wr_en) cnt <= cnt + TW'(1);
          if (accept) begin
            buf_q   <= i_data;
            lane_q  <= '0;
            wr_en   <= 1'b1;
            acc_cnt <= acc_cnt + (TW+1)'(1);
          end else if (wr_en) begin
            // Trailing lanes of the final word are dropped once the tile is complete.
            if (last_elem || last_lane) wr_en  <= 1'b0;
            else                        lane_q <= lane_q + LW'(1);
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_fetch_pp.sv
// Randomised bench for feature_fetch_pp: tiles are driven word by word while a
// negedge monitor pops expected {bank, addr, data} writes from a queue.
module tb_feature_fetch_pp;

  localparam int IN_W   = 128;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int SIZE_W = 8;
  localparam int CH_W   = 8;
  localparam int LANES  = IN_W / DATA_W;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  logic              clk, rst, start, bank_hold, feature_in_select, i_valid;
  logic [SIZE_W-1:0] feature_size;
  logic [CH_W-1:0]   channels;
  logic [IN_W-1:0]   i_data;
  logic              i_ready, wr_en, i_mem_select, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic exp_bank = 1'b0;

  feature_fetch_pp #(
    .IN_W(IN_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .feature_size(feature_size),
    .channels(channels), .bank_hold(bank_hold), .feature_in_select(feature_in_select),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .i_mem_select(i_mem_select), .busy(busy),
    .done(done), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
      else check("write_bank_addr_data", {i_mem_select, wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_i_mem_select"}, i_mem_select, 0);
    check({tag, "_i_ready"}, i_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // driver: mode 0 = valid held high, mode 1 = valid on even cycles only;
  // overdrive keeps junk words offered after the last real one.
  task automatic run_tile(input int size, input int ch, input bit hold, input bit sel,
                          input int mode, input bit overdrive, input int abort_k);
    int total, nwords, widx, acc, done_k, limit;
    bit reject, empty, rdy_prev, v_prev;
    logic [IN_W-1:0] wq[$];
    logic [IN_W-1:0] w;
    total  = size * size * ch;
    reject = total > (1 << ADDR_W);
    empty  = (total == 0);
    nwords = reject ? 0 : (total + LANES - 1) / LANES;
    for (int i = 0; i < nwords; i++) wq.push_back(rand_word());
    if (!reject) exp_bank = hold ? sel : ~exp_bank;
    if (!reject)
      for (int e = 0; e < total; e++) begin
        w = wq[e / LANES];
        exp_q.push_back({exp_bank, ADDR_W'(e), w[(e % LANES) * DATA_W +: DATA_W]});
      end

    @(negedge clk);
    start = 1'b1;
    feature_size = SIZE_W'(size);
    channels = CH_W'(ch);
    bank_hold = hold;
    feature_in_select = sel;
    i_valid = 1'b0;
    rdy_prev = 1'b0; v_prev = 1'b0; widx = 0; acc = 0; done_k = -1;
    limit = 4 * total + 50;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (v_prev && rdy_prev) begin
        acc++;
        if (widx < nwords) widx++;
      end
      if (k == 1) begin
        check("busy_after_start", busy, !(reject || empty));
        check("ready_after_start", i_ready, !(reject || empty));
        check("err_after_start", err, reject);
      end
      if (done) begin done_k = k; break; end
      if (abort_k > 0 && k == abort_k) break;
      rdy_prev = i_ready;
      v_prev = (widx < nwords && (mode == 0 || k % 2 == 0)) || (overdrive && widx >= nwords);
      i_valid = v_prev;
      i_data = (widx < nwords) ? wq[widx] : rand_word();
    end
    i_valid = 1'b0;
    if (abort_k > 0) return;
    if (done_k < 0) check("done_timeout", 64'd1, 64'd0);
    else begin
      if (mode == 0) check("done_cycle", done_k, (reject || empty) ? 1 : total + 2);
      check("busy_at_done", busy, 0);
      check("words_accepted", acc, nwords);
      check("bank_after_tile", i_mem_select, exp_bank);
      check("err_after_tile", err, reject);
      check("writes_outstanding", exp_q.size(), 0);
    end
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; feature_size = '0; channels = '0; bank_hold = 1'b0;
    feature_in_select = 1'b0; i_valid = 1'b0; i_data = '0;
    #1 check_reset_values("reset_hold");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    run_tile(4, 1, 1'b0, 1'b0, 0, 1'b0, 0);    // 16 elements, bank 1
    run_tile(3, 1, 1'b0, 1'b0, 0, 1'b1, 0);    // 9 elements, junk offered after word 2
    run_tile(4, 2, 1'b0, 1'b0, 0, 1'b0, 0);    // third auto tile, bank 1
    run_tile(4, 1, 1'b1, 1'b1, 0, 1'b0, 0);    // held bank 1
    run_tile(8, 1, 1'b0, 1'b0, 1, 1'b0, 0);    // 64 elements, gappy valid
    run_tile(255, 1, 1'b0, 1'b0, 0, 1'b0, 0);  // rejected, bank unchanged
    run_tile(5, 3, 1'b1, 1'b0, 0, 1'b0, 0);    // clears err, partial last word
    run_tile(0, 2, 1'b0, 1'b0, 0, 1'b0, 0);    // empty tile
    run_tile(182, 1, 1'b0, 1'b0, 0, 1'b0, 0);  // just over bank depth
    run_tile(128, 2, 1'b0, 1'b0, 0, 1'b0, 0);  // exactly bank depth
    for (int t = 0; t < 8; t++)
      run_tile($urandom_range(1, 7), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0);

    run_tile(8, 1, 1'b0, 1'b0, 0, 1'b0, 6);    // abandoned mid-fetch by reset
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    exp_q.delete();
    exp_bank = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_mid_tile");
    #2 rst = 1'b0;
    run_tile(4, 1, 1'b0, 1'b0, 0, 1'b0, 0);    // fresh tile from addr 0

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
